coffee_dispenser: RTL and testbench

COFFEE_DISPENSER -- requirements
Module: coffee_dispenser

---
 rtl/coffee_dispenser.sv | 117 +++++++++++
 tb/tb_coffee_dispenser.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/coffee_dispenser.sv
// Drink sequencer: cup drop, water pour, optional milk pour, then a one-cycle
// completion pulse. Valve outputs are Moore-decoded from the state register.
module coffee_dispenser #(
  parameter int CUP_CYC  = 4,
  parameter int POUR_CYC = 8,
  parameter int MILK_CYC = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       exprr,
  input  logic       expr_1,
  input  logic       capp,
  output logic       cup_valve,
  output logic       water_valve,
  output logic       milk_valve,
  output logic       busy,
  output logic       done,
  output logic       drop,
  output logic [1:0] drink_code,
  output logic [7:0] served_cnt
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CUP  = 3'd1;
  localparam logic [2:0] S_POUR = 3'd2;
  localparam logic [2:0] S_MILK = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [1:0] D_ESPR = 2'b01;
  localparam logic [1:0] D_LONG = 2'b10;
  localparam logic [1:0] D_CAPP = 2'b11;

  // Timer loads are "cycles - 1": a phase ends on the cycle the timer reads 0.
  localparam logic [7:0] CUP_LOAD  = 8'(CUP_CYC - 1);
  localparam logic [7:0] POUR_LOAD = 8'(POUR_CYC - 1);
  localparam logic [7:0] LONG_LOAD = 8'(2 * POUR_CYC - 1);
  localparam logic [7:0] MILK_LOAD = 8'(MILK_CYC - 1);

  logic [2:0] state;
  logic [7:0] timer;
  logic [1:0] drink;
  logic [1:0] req_code;
  logic       any_req;

  assign any_req = exprr | expr_1 | capp;

  always_comb begin
    req_code = 2'b00;
    if (capp)        req_code = D_CAPP;
    else if (expr_1) req_code = D_LONG;
    else if (exprr)  req_code = D_ESPR;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      timer      <= 8'd0;
      drink      <= 2'b00;
      served_cnt <= 8'd0;
      drop       <= 1'b0;
    end else begin
      // Any request arriving while a drink is in flight is discarded.
      drop <= (state != S_IDLE) && any_req;
      case (state)
        S_IDLE: begin
          if (any_req) begin
            state <= S_CUP;
            timer <= CUP_LOAD;
            drink <= req_code;
          end
        end
        S_CUP: begin
          if (timer == 8'd0) begin
            state <= S_POUR;
            timer <= (drink == D_LONG) ? LONG_LOAD : POUR_LOAD;
          end else begin
            timer <= timer - 8'd1;
          end
        end
        S_POUR: begin
          if (timer == 8'd0) begin
            if (drink == D_CAPP) begin
              state <= S_MILK;
              timer <= MILK_LOAD;
            end else begin
              state <= S_DONE;
            end
          end else begin
            timer <= timer - 8'd1;
          end
        end
        S_MILK: begin
          if (timer == 8'd0) state <= S_DONE;
          else               timer <= timer - 8'd1;
        end
        S_DONE: begin
          state      <= S_IDLE;
          drink      <= 2'b00;
          served_cnt <= served_cnt + 8'd1;
        end
        default: begin
          state <= S_IDLE;
          timer <= 8'd0;
          drink <= 2'b00;
        end
      endcase
    end
  end

  assign cup_valve   = (state == S_CUP);
  assign water_valve = (state == S_POUR);
  assign milk_valve  = (state == S_MILK);
  assign done        = (state == S_DONE);
  assign busy        = (state != S_IDLE);
  assign drink_code  = drink;

endmodule

// File: tb/tb_coffee_dispenser.sv
// Directed bench for coffee_dispenser: per-cycle expected output vectors are
// queued from a timeline model and popped/compared one cycle at a time.
module tb_coffee_dispenser;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       exprr = 1'b0;
  logic       expr_1 = 1'b0;
  logic       capp = 1'b0;
  logic       cup_valve, water_valve, milk_valve, busy, done, drop;
  logic [1:0] drink_code;
  logic [7:0] served_cnt;

  int compared = 0;
  int mismatched = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  model_served = 8'd0;

  always #5 clk = ~clk;

  coffee_dispenser dut (
    .clk(clk), .rst(rst), .exprr(exprr), .expr_1(expr_1), .capp(capp),
    .cup_valve(cup_valve), .water_valve(water_valve), .milk_valve(milk_valve),
    .busy(busy), .done(done), .drop(drop), .drink_code(drink_code),
    .served_cnt(served_cnt)
  );

  // Vector layout: {cup, water, milk, busy, done, drop, code[1:0], served[7:0]}
  function automatic logic [15:0] mk(input logic cup, input logic water,
                                     input logic milk, input logic bsy,
                                     input logic dn, input logic drp,
                                     input logic [1:0] code, input logic [7:0] srv);
    return {cup, water, milk, bsy, dn, drp, code, srv};
  endfunction

  task automatic push_idle();
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 2'b00, model_served));
  endtask

  // Expected outputs for the cycles after the accepting edge, ending with
  // the first IDLE cycle that shows the incremented count.
  task automatic push_drink(input logic [1:0] code);
    int pour_len;
    pour_len = (code == 2'b10) ? 16 : 8;
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(1, 0, 0, 1, 0, 0, code, model_served));
    for (int i = 0; i < pour_len; i++) exp_q.push_back(mk(0, 1, 0, 1, 0, 0, code, model_served));
    if (code == 2'b11)
      for (int i = 0; i < 6; i++) exp_q.push_back(mk(0, 0, 1, 1, 0, 0, code, model_served));
    exp_q.push_back(mk(0, 0, 0, 1, 1, 0, code, model_served));
    model_served = model_served + 8'd1;
    push_idle();
  endtask

  task automatic run_cycles(input string tag, input int n);
    logic [15:0] obs;
    logic [15:0] expv;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      exprr = 1'b0; expr_1 = 1'b0; capp = 1'b0;
      obs = {cup_valve, water_valve, milk_valve, busy, done, drop, drink_code, served_cnt};
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $error("FAIL %s: expected queue empty, observed=%h", tag, obs);
      end else begin
        expv = exp_q.pop_front();
        assert (obs === expv) else begin
          mismatched++;
          $error("FAIL %s cycle %0d: observed=%h expected=%h", tag, i + 1, obs, expv);
        end
      end
    end
  endtask

  initial begin
    // Reset state
    push_idle(); push_idle();
    run_cycles("reset", 2);
    rst = 1'b0;
    push_idle();
    run_cycles("idle", 1);

    // Espresso: full timeline including count in the following idle cycle
    push_drink(2'b01);
    exprr = 1'b1;
    run_cycles("espresso", exp_q.size());

    // Long espresso: double pour
    push_drink(2'b10);
    expr_1 = 1'b1;
    run_cycles("long", exp_q.size());

    // Cappuccino with milk phase
    push_drink(2'b11);
    capp = 1'b1;
    run_cycles("capp", exp_q.size());

    // Simultaneous exprr+capp resolves to cappuccino; extra exprr in POUR drops
    push_drink(2'b11);
    exprr = 1'b1; capp = 1'b1;
    run_cycles("prio", 6);
    exprr = 1'b1;
    exp_q[0][10] = 1'b1;
    run_cycles("prio_drop", exp_q.size());

    // Request seen during DONE is discarded; FSM stays idle afterwards
    push_drink(2'b01);
    exprr = 1'b1;
    run_cycles("done_req", 13);
    expr_1 = 1'b1;
    exp_q[0][10] = 1'b1;
    push_idle();
    run_cycles("done_drop", exp_q.size());

    // Reset during POUR aborts the drink and overrides a same-cycle request
    push_drink(2'b01);
    exprr = 1'b1;
    run_cycles("pre_abort", 6);
    exp_q.delete();
    model_served = 8'd0;
    rst = 1'b1; capp = 1'b1;
    push_idle();
    run_cycles("abort", 1);
    rst = 1'b0;
    push_idle(); push_idle(); push_idle();
    run_cycles("post_abort", 3);

    // 256 back-to-back espressos: count reaches 255 then wraps to 0
    for (int d = 0; d < 256; d++) begin
      push_drink(2'b01);
      exprr = 1'b1;
      run_cycles("wrap", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
